// File: rtl/multicycle_datapath.sv
// multicycle_datapath: IDLE/READ/EXEC/MEM/WB datapath with register file, ALU and data memory.
// Define MULTIPLY_EN to add an iterative shift-add multiplier for alu_ctrl 1000.
module multicycle_datapath #(
  parameter int WIDTH = 32,
  parameter int REG_COUNT = 32,
  parameter int MEM_DEPTH = 64,
  localparam int AW = $clog2(REG_COUNT)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clock_enable,
  input  logic             instr_valid,
  output logic             instr_ready,
  input  logic [AW-1:0]    rs,
  input  logic [AW-1:0]    rt,
  input  logic [AW-1:0]    rd,
  input  logic [WIDTH-1:0] imm,
  input  logic             reg_dst,
  input  logic             reg_write,
  input  logic             alu_src,
  input  logic             mem_write,
  input  logic             mem_to_reg,
  input  logic [3:0]       alu_ctrl,
  output logic [WIDTH-1:0] alu_out,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             busy,
  output logic             done
);
  localparam int MW = $clog2(MEM_DEPTH);
  typedef enum logic [2:0] {IDLE, READ, EXEC, MEM, WB} state_t;
  state_t state, state_nxt;
  logic [WIDTH-1:0] rf [REG_COUNT];
  logic [WIDTH-1:0] mem [MEM_DEPTH];
  logic [WIDTH-1:0] a, b, imm_q, op2, alu_res, mem_rd, rd_a, rd_b, mul_res;
  logic [AW-1:0] rs_q, rt_q, rd_q, wa;
  logic reg_dst_q, reg_write_q, alu_src_q, mem_write_q, mem_to_reg_q, mul_hold;
  logic [3:0] alu_ctrl_q;
  logic [MW-1:0] idx;

  assign rd_a = rs_q == '0 ? '0 : rf[rs_q];
  assign rd_b = rt_q == '0 ? '0 : rf[rt_q];
  assign op2 = alu_src_q ? imm_q : b;
  assign idx = alu_out[MW-1:0];
  assign mem_rd = mem_write_q ? b : mem[idx];
  assign wa = reg_dst_q ? rd_q : rt_q;
  assign instr_ready = state == IDLE;
  assign busy = state != IDLE;
  assign done = state == WB;
  assign zero = alu_out == '0;

`ifdef MULTIPLY_EN
  localparam int CW = $clog2(WIDTH);
  logic [WIDTH-1:0] mc, mp, acc;
  logic [CW-1:0] cnt;
  // one multiplier bit per EXEC cycle; the last partial sum goes straight to alu_out
  assign mul_res = acc + (mp[0] ? mc : '0);
  assign mul_hold = alu_ctrl_q == 4'b1000 && cnt != CW'(WIDTH - 1);
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      {mc, mp, acc} <= '0;
      cnt <= '0;
    end else if (clock_enable && state == READ) begin
      mc <= rd_a;
      mp <= alu_src_q ? imm_q : rd_b;
      acc <= '0;
      cnt <= '0;
    end else if (clock_enable && state == EXEC) begin
      acc <= mul_res;
      mc <= mc << 1;
      mp <= mp >> 1;
      cnt <= cnt + CW'(1);
    end
`else
  assign mul_res = '0;
  assign mul_hold = 1'b0;
`endif

  always_comb begin
    alu_res = '0;
    case (alu_ctrl_q)
      4'b0000: alu_res = a & op2;
      4'b0001: alu_res = a | op2;
      4'b0010: alu_res = a + op2;
      4'b0110: alu_res = a - op2;
      4'b0111: alu_res = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(op2)};
      4'b1100: alu_res = ~(a | op2);
      4'b1000: alu_res = mul_res;
      default: alu_res = '0;
    endcase
  end

  always_ff @(posedge clock or posedge reset)
    if (reset) state <= IDLE;
    else if (clock_enable) state <= state_nxt;

  always_comb begin
    state_nxt = IDLE;
    case (state)
      IDLE: state_nxt = instr_valid ? READ : IDLE;
      READ: state_nxt = EXEC;
      EXEC: state_nxt = mul_hold ? EXEC : MEM;
      MEM: state_nxt = WB;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      for (int i = 0; i < REG_COUNT; i++) rf[i] <= '0;
      {a, b, imm_q, alu_out, result} <= '0;
      {rs_q, rt_q, rd_q} <= '0;
      {reg_dst_q, reg_write_q, alu_src_q, mem_write_q, mem_to_reg_q} <= '0;
      alu_ctrl_q <= '0;
    end else if (clock_enable) begin
      case (state)
        IDLE: if (instr_valid) begin
          rs_q <= rs;
          rt_q <= rt;
          rd_q <= rd;
          imm_q <= imm;
          {reg_dst_q, reg_write_q, alu_src_q, mem_write_q, mem_to_reg_q} <= {reg_dst, reg_write, alu_src, mem_write, mem_to_reg};
          alu_ctrl_q <= alu_ctrl;
        end
        READ: begin
          a <= rd_a;
          b <= rd_b;
        end
        EXEC: if (!mul_hold) alu_out <= alu_res;
        MEM: result <= mem_to_reg_q ? mem_rd : alu_out;
        WB: if (reg_write_q && wa != '0) rf[wa] <= result;
        default: ;
      endcase
    end

  // data memory is deliberately left out of reset
  always_ff @(posedge clock)
    if (clock_enable && state == MEM && mem_write_q) mem[idx] <= b;
endmodule

// File: tb/tb_multicycle_datapath.sv
// tb_multicycle_datapath: scoreboard bench with a behavioural register/memory model.
module tb_multicycle_datapath;
  localparam int W = 32, RC = 32, MD = 64;
`ifdef MULTIPLY_EN
  localparam int MUL_LAT = 4 + W - 1;
`else
  localparam int MUL_LAT = 4;
`endif
  logic clock = 0, reset = 1, clock_enable = 1, instr_valid = 0;
  logic instr_ready, zero, busy, done;
  logic [4:0] rs = 0, rt = 0, rd = 0;
  logic [W-1:0] imm = 0, alu_out, result;
  logic reg_dst = 0, reg_write = 0, alu_src = 0, mem_write = 0, mem_to_reg = 0;
  logic [3:0] alu_ctrl = 0;

  multicycle_datapath dut (
    .clock(clock), .reset(reset), .clock_enable(clock_enable), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .rs(rs), .rt(rt), .rd(rd), .imm(imm), .reg_dst(reg_dst),
    .reg_write(reg_write), .alu_src(alu_src), .mem_write(mem_write), .mem_to_reg(mem_to_reg),
    .alu_ctrl(alu_ctrl), .alu_out(alu_out), .result(result), .zero(zero), .busy(busy), .done(done)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [W-1:0] alu;
    logic [W-1:0] res;
    int acc;
    int lat;
  } exp_t;
  exp_t q[$];
  exp_t me;
  logic [W-1:0] rf [RC];
  logic [W-1:0] mm [MD];
  logic [3:0] ops [8] = '{4'd0, 4'd1, 4'd2, 4'd6, 4'd7, 4'd12, 4'd8, 4'd3};
  int cyc = 0, n_cmp = 0, n_bad = 0;
  bit done_q = 0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // monitor: one completion per rising edge of done
  always @(negedge clock) begin
    if (!reset && done && !done_q) begin
      if (q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL spurious_done at cycle %0d", cyc);
      end else begin
        me = q.pop_front();
        chk("alu_out", alu_out, me.alu);
        chk("result", result, me.res);
        chk("zero", {31'b0, zero}, {31'b0, me.alu == 0});
        chk("latency", cyc - me.acc, me.lat);
      end
    end
    done_q = done;
  end

  task automatic issue(input logic [3:0] op, input int s, t, d, input logic [W-1:0] im,
                       input bit rdst, rw, asrc, mw, m2r, input bit keep = 1, input int extra = 0);
    logic [W-1:0] av, bv, o2, al, ld;
    int n, ix, w, k;
    exp_t e;
    n = 0;
    @(negedge clock);
    while (!instr_ready && n < 400) begin
      @(negedge clock);
      n++;
    end
    if (!instr_ready) begin
      n_cmp++;
      n_bad++;
      $display("FAIL ready_timeout at cycle %0d", cyc);
      return;
    end
    rs = 5'(s); rt = 5'(t); rd = 5'(d); imm = im; alu_ctrl = op;
    {reg_dst, reg_write, alu_src, mem_write, mem_to_reg} = {rdst, rw, asrc, mw, m2r};
    instr_valid = 1;
    av = s == 0 ? '0 : rf[s];
    bv = t == 0 ? '0 : rf[t];
    o2 = asrc ? im : bv;
    case (op)
      4'd0: al = av & o2;
      4'd1: al = av | o2;
      4'd2: al = av + o2;
      4'd6: al = av - o2;
      4'd7: al = ($signed(av) < $signed(o2)) ? 1 : 0;
      4'd12: al = ~(av | o2);
`ifdef MULTIPLY_EN
      4'd8: al = av * o2;
`endif
      default: al = 0;
    endcase
    @(posedge clock);
    #1;
    k = cyc - 1;
    instr_valid = 0;
    rs = 5'($urandom_range(0, 31)); rt = 5'($urandom_range(0, 31)); rd = 5'($urandom_range(0, 31));
    imm = $urandom; alu_ctrl = 4'($urandom_range(0, 15));
    {reg_dst, reg_write, alu_src, mem_write, mem_to_reg} = 5'($urandom_range(0, 31));
    chk("busy_after_accept", {31'b0, busy}, 1);
    chk("ready_after_accept", {31'b0, instr_ready}, 0);
    if (keep) begin
      ix = int'(al % MD);
      if (mw) mm[ix] = bv;
      ld = mm[ix];
      e.alu = al;
      e.res = m2r ? ld : al;
      e.acc = k;
      e.lat = (op == 4'd8 ? MUL_LAT : 4) + extra;
      q.push_back(e);
      w = rdst ? d : t;
      if (rw && w != 0) rf[w] = e.res;
    end
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_busy"}, {31'b0, busy}, 0);
    chk({tag, "_ready"}, {31'b0, instr_ready}, 1);
    chk({tag, "_done"}, {31'b0, done}, 0);
    chk({tag, "_zero"}, {31'b0, zero}, 1);
    chk({tag, "_alu_out"}, alu_out, 0);
    chk({tag, "_result"}, result, 0);
  endtask

  initial begin
    int n;
    bit mw;
    for (int i = 0; i < RC; i++) rf[i] = 0;
    for (int i = 0; i < MD; i++) mm[i] = 0;
    repeat (2) @(posedge clock);
    #1;
    chk_reset_state("rst");
    reset = 0;
    for (int i = 0; i < MD; i++) issue(4'd2, 0, 0, 0, i, 0, 0, 1, 1, 0);
    issue(4'd2, 0, 1, 0, 5, 0, 1, 1, 0, 0);
    issue(4'd2, 0, 2, 0, 7, 0, 1, 1, 0, 0);
    issue(4'd6, 1, 2, 3, 0, 1, 1, 0, 0, 0);
    issue(4'd7, 1, 2, 4, 0, 1, 1, 0, 0, 0);
    issue(4'd2, 0, 2, 0, 66, 0, 0, 1, 1, 0);
    issue(4'd2, 0, 5, 0, 2, 0, 1, 1, 0, 1);
    issue(4'd2, 0, 0, 0, 9, 1, 1, 1, 0, 0);
    issue(4'd1, 0, 0, 6, 0, 1, 1, 0, 0, 0);
    issue(4'd2, 1, 2, 7, 0, 1, 1, 0, 0, 0, 1, 3);
    @(posedge clock);
    #1 clock_enable = 0;
    repeat (3) @(posedge clock);
    #1 clock_enable = 1;
    issue(4'd1, 2, 8, 0, 32'hF0, 0, 1, 1, 0, 0);
    n = 0;
    while (!done && n < 100) begin
      @(negedge clock);
      n++;
    end
    clock_enable = 0;
    @(negedge clock);
    chk("wb_stall_done1", {31'b0, done}, 1);
    @(negedge clock);
    chk("wb_stall_done2", {31'b0, done}, 1);
    clock_enable = 1;
    @(negedge clock);
    chk("wb_release_done", {31'b0, done}, 0);
    issue(4'd2, 0, 1, 0, 99, 0, 1, 1, 0, 0, 0);
    @(posedge clock);
    #2 reset = 1;
    #1 chk_reset_state("abort");
    @(posedge clock);
    #1 reset = 0;
    for (int i = 0; i < RC; i++) rf[i] = 0;
    issue(4'd1, 1, 0, 9, 0, 1, 1, 1, 0, 0);
    issue(4'd2, 0, 1, 0, 6, 0, 1, 1, 0, 0);
    issue(4'd2, 0, 2, 0, 7, 0, 1, 1, 0, 0);
    issue(4'd8, 1, 2, 10, 0, 1, 1, 0, 0, 0);
    for (int i = 0; i < 40; i++) begin
      mw = $urandom_range(0, 3) == 0;
      issue(ops[$urandom_range(0, 7)], $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
            $urandom_range(0, 1) ? $urandom : 32'($urandom_range(0, 200)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), mw,
            mw ? 1'b0 : 1'($urandom_range(0, 1)));
    end
    n = 0;
    while (q.size() != 0 && n < 200) begin
      @(negedge clock);
      n++;
    end
    if (q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain_timeout: %0d completions outstanding, required 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
